// File: rtl/warp_scheduler.sv
// Round-robin issue scheduler: grants one resident warp the execution pipeline per
// instruction, holds the grant until retirement, and reports block completion.
module warp_scheduler #(
  parameter int NUM_WARPS    = 4,
  parameter int WARP_ID_BITS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NUM_WARPS-1:0]    warp_active,
  input  logic [NUM_WARPS-1:0]    warp_ready,
  input  logic                    step_done,
  input  logic                    step_ret,
  output logic                    issue_valid,
  output logic [WARP_ID_BITS-1:0] issue_warp_id,
  output logic [NUM_WARPS-1:0]    active_mask,
  output logic                    busy,
  output logic                    block_done
);

  typedef enum logic [1:0] {IDLE, SELECT, ISSUE, DONE} state_t;

  localparam logic [WARP_ID_BITS-1:0] LAST_WARP = WARP_ID_BITS'(NUM_WARPS - 1);

  state_t                  state;
  logic [WARP_ID_BITS-1:0] last_grant;
  logic [NUM_WARPS-1:0]    cand;
  logic [NUM_WARPS-1:0]    mask_after;
  logic [WARP_ID_BITS-1:0] probe;
  logic [WARP_ID_BITS-1:0] pick_id;
  logic                    pick_valid;

  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    cand       = active_mask & warp_ready;
    pick_valid = 1'b0;
    pick_id    = '0;
    probe      = '0;
    // Walk from the farthest offset down to last_grant+1 so the nearest candidate wins;
    // offset NUM_WARPS wraps back onto last_grant itself (sole-candidate re-grant).
    for (int i = NUM_WARPS; i >= 1; i--) begin
      probe = last_grant + WARP_ID_BITS'(i);
      if (cand[probe]) begin
        pick_valid = 1'b1;
        pick_id    = probe;
      end
    end
    mask_after = active_mask;
    if (step_ret) mask_after[issue_warp_id] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      issue_valid   <= 1'b0;
      issue_warp_id <= '0;
      active_mask   <= '0;
      busy          <= 1'b0;
      block_done    <= 1'b0;
      last_grant    <= LAST_WARP;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            active_mask <= warp_active;
            last_grant  <= LAST_WARP;
            if (warp_active == '0) begin
              state      <= DONE;
              busy       <= 1'b0;
              block_done <= 1'b1;
            end else begin
              state      <= SELECT;
              busy       <= 1'b1;
              block_done <= 1'b0;
            end
          end
        end
        SELECT: begin
          if (pick_valid) begin
            issue_warp_id <= pick_id;
            issue_valid   <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (step_done) begin
            issue_valid <= 1'b0;
            last_grant  <= issue_warp_id;
            active_mask <= mask_after;
            if (mask_after == '0) begin
              state      <= DONE;
              busy       <= 1'b0;
              block_done <= 1'b1;
            end else begin
              state <= SELECT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_warp_scheduler.sv
// Bench for warp_scheduler: a phase-level reference model checked every cycle, plus
// directed scenarios with hand-computed grant orders and masks.
module tb_warp_scheduler;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset, start, step_done, step_ret;
  logic [N-1:0] warp_active, warp_ready;
  logic         issue_valid, busy, block_done;
  logic [1:0]   issue_warp_id;
  logic [N-1:0] active_mask;

  int vectors = 0;
  int miscompares = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  warp_scheduler #(.NUM_WARPS(N), .WARP_ID_BITS(2)) dut (
    .clk(clk), .reset(reset), .start(start),
    .warp_active(warp_active), .warp_ready(warp_ready),
    .step_done(step_done), .step_ret(step_ret),
    .issue_valid(issue_valid), .issue_warp_id(issue_warp_id),
    .active_mask(active_mask), .busy(busy), .block_done(block_done)
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what phase the block is in, which warps remain, who holds the pipe.
  typedef enum {P_IDLE, P_SELECT, P_ISSUE, P_DONE} phase_t;
  phase_t m_phase = P_IDLE;
  int     m_mask = 0, m_id = 0, m_last = N - 1, m_cand = 0;
  bit     m_valid = 1'b0, m_found;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = P_IDLE; m_valid = 1'b0; m_id = 0; m_mask = 0; m_last = N - 1;
    end else begin
      case (m_phase)
        P_IDLE, P_DONE: if (start) begin
          m_mask  = int'(warp_active);
          m_last  = N - 1;
          m_phase = (m_mask == 0) ? P_DONE : P_SELECT;
        end
        P_SELECT: begin
          m_cand  = m_mask & int'(warp_ready);
          m_found = 1'b0;
          for (int k = 1; k <= N; k++) begin
            if (!m_found && m_cand[(m_last + k) % N]) begin
              m_found = 1'b1;
              m_id    = (m_last + k) % N;
            end
          end
          if (m_found) begin
            m_valid = 1'b1;
            m_phase = P_ISSUE;
          end
        end
        P_ISSUE: if (step_done) begin
          m_valid = 1'b0;
          m_last  = m_id;
          if (step_ret) m_mask = m_mask & ~(1 << m_id);
          m_phase = (m_mask == 0) ? P_DONE : P_SELECT;
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("issue_valid", int'(issue_valid), int'(m_valid));
      if (m_valid) check("issue_warp_id", int'(issue_warp_id), m_id);
      check("active_mask", int'(active_mask), m_mask);
      check("busy", int'(busy), int'(m_phase == P_SELECT || m_phase == P_ISSUE));
      check("block_done", int'(block_done), int'(m_phase == P_DONE));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; step_done = 1'b0; step_ret = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  task automatic do_start(input logic [N-1:0] act);
    start = 1'b1; warp_active = act;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_grant(output int id);
    bit got = 1'b0;
    id = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      if (issue_valid) got = 1'b1;
      else cyc();
    end
    if (!got) check("grant_timeout", 0, 1);
    else id = int'(issue_warp_id);
  endtask

  task automatic pulse_step(input bit ret);
    step_done = 1'b1; step_ret = ret;
    cyc();
    step_done = 1'b0; step_ret = 1'b0;
  endtask

  task automatic grant_step(input string name, input int exp_id, input bit ret);
    int id;
    wait_grant(id);
    check(name, id, exp_id);
    pulse_step(ret);
  endtask

  initial begin
    int id;
    reset = 1'b1; start = 1'b0; step_done = 1'b0; step_ret = 1'b0;
    warp_active = '0; warp_ready = '0;

    // Full round-robin with every warp ready; grant two cycles after start.
    do_reset();
    armed = 1'b1;
    check("reset_valid", int'(issue_valid), 0);
    check("reset_mask", int'(active_mask), 0);
    warp_ready = 4'b1111;
    do_start(4'b1111);
    check("lat_n1_valid", int'(issue_valid), 0);
    check("lat_n1_busy", int'(busy), 1);
    cyc();
    check("lat_n2_valid", int'(issue_valid), 1);
    check("lat_n2_id", int'(issue_warp_id), 0);
    grant_step("rr_g0", 0, 1'b0);
    grant_step("rr_g1", 1, 1'b0);
    grant_step("rr_g2", 2, 1'b0);
    grant_step("rr_g3", 3, 1'b0);
    grant_step("rr_g4", 0, 1'b0);
    grant_step("rr_g5", 1, 1'b0);

    // Sparse readiness, then warp 1 becomes ready while warp 2 holds the pipe.
    do_reset();
    warp_ready = 4'b0101;
    do_start(4'b1111);
    grant_step("sp_g0", 0, 1'b0);
    grant_step("sp_g1", 2, 1'b0);
    grant_step("sp_g2", 0, 1'b0);
    wait_grant(id);
    check("sp_g3", id, 2);
    warp_ready = 4'b0111;
    pulse_step(1'b0);
    grant_step("sp_g4", 0, 1'b0);
    grant_step("sp_g5", 1, 1'b0);
    grant_step("sp_g6", 2, 1'b0);

    // Retirement of a partial block.
    do_reset();
    warp_ready = 4'b1111;
    do_start(4'b1011);
    grant_step("ret_g0", 0, 1'b1);
    check("ret_mask0", int'(active_mask), 4'b1010);
    grant_step("ret_g1", 1, 1'b1);
    check("ret_mask1", int'(active_mask), 4'b1000);
    grant_step("ret_g2", 3, 1'b1);
    check("ret_mask2", int'(active_mask), 0);
    check("ret_done", int'(block_done), 1);
    check("ret_busy", int'(busy), 0);
    check("ret_valid", int'(issue_valid), 0);

    // Starvation in SELECT, then only warp 3 ready; search wraps back to warp 0.
    do_reset();
    warp_ready = 4'b0000;
    do_start(4'b1111);
    for (int i = 0; i < 5; i++) begin
      check("starve_valid", int'(issue_valid), 0);
      check("starve_busy", int'(busy), 1);
      cyc();
    end
    warp_ready = 4'b1000;
    grant_step("wrap_g0", 3, 1'b0);
    warp_ready = 4'b1111;
    grant_step("wrap_g1", 0, 1'b0);

    // Empty block completes at once; a second start runs normally.
    do_reset();
    do_start(4'b0000);
    check("empty_done", int'(block_done), 1);
    check("empty_busy", int'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      check("empty_valid", int'(issue_valid), 0);
      cyc();
    end
    do_start(4'b0001);
    check("restart_busy", int'(busy), 1);
    check("restart_done", int'(block_done), 0);
    grant_step("restart_g0", 0, 1'b0);

    // Reset in the middle of an issue.
    do_reset();
    warp_ready = 4'b0100;
    do_start(4'b1111);
    wait_grant(id);
    check("mid_grant", id, 2);
    reset = 1'b1;
    cyc();
    check("mid_rst_valid", int'(issue_valid), 0);
    check("mid_rst_mask", int'(active_mask), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(block_done), 0);
    reset = 1'b0;
    warp_ready = 4'b1111;
    do_start(4'b1111);
    grant_step("post_rst_g0", 0, 1'b0);

    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
